// File: rtl/bus_timer_slave_if.sv
// Bus-side signal bundle for the interval timer slave.
interface bus_timer_slave_if;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;
  logic        irq;

  modport master (output cs_, as_, rw, addr, wr_data, input rd_data, rdy_, irq);
  modport slave  (input cs_, as_, rw, addr, wr_data, output rd_data, rdy_, irq);
endinterface

// File: rtl/bus_timer_slave.sv
// 32-bit programmable interval timer bus slave: one-shot/periodic expiry,
// sticky interrupt flag, configurable bus wait states.
module bus_timer_slave #(
  parameter int unsigned RDY_WAIT = 0
) (
  input  logic             clk,
  input  logic             reset_,
  bus_timer_slave_if.slave bus
);

  localparam logic [3:0] WAIT_LOAD = 4'((RDY_WAIT > 0) ? RDY_WAIT - 1 : 0);
  localparam logic       NO_WAIT   = (RDY_WAIT == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        rw_q, rw_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rdy_q, rdy_d;

  logic        start_q, start_d;
  logic        periodic_q, periodic_d;
  logic        flag_q, flag_d;
  logic [31:0] expr_q, expr_d;
  logic [31:0] count_q, count_d;

  logic        req;
  logic        wr_en;
  logic        expire;
  logic [1:0]  rd_addr;
  logic [31:0] reg_val;

  assign req    = ~bus.cs_ & ~bus.as_;
  assign wr_en  = (state_q == S_IDLE) & req & ~bus.rw;
  assign expire = start_q & (count_q == expr_q);

  // With no wait states ACK is entered on the accepting edge, so the read
  // mux must look at the live address rather than the latched one.
  always_comb begin
    rd_addr = (state_q == S_IDLE) ? bus.addr : addr_q;
    case (rd_addr)
      2'd0:    reg_val = {30'd0, periodic_q, start_q};
      2'd1:    reg_val = {31'd0, flag_q};
      2'd2:    reg_val = expr_q;
      default: reg_val = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    rd_data_d = '0;
    rdy_d     = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          rw_d   = bus.rw;
          addr_d = bus.addr;
          if (NO_WAIT) begin
            state_d = S_ACK;
            rdy_d   = 1'b0;
            if (bus.rw) rd_data_d = reg_val;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = S_ACK;
          rdy_d   = 1'b0;
          if (rw_q) rd_data_d = reg_val;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus writes override the timer's own updates, except that an expiry
  // always sets FLAG so a coincident software clear cannot lose it.
  always_comb begin
    start_d    = start_q;
    periodic_d = periodic_q;
    flag_d     = flag_q;
    expr_d     = expr_q;
    count_d    = count_q;

    if (start_q) count_d = expire ? '0 : count_q + 32'd1;
    if (expire && !periodic_q) start_d = 1'b0;
    if (wr_en && bus.addr == 2'd1) flag_d = bus.wr_data[0];
    if (expire) flag_d = 1'b1;

    if (wr_en) begin
      case (bus.addr)
        2'd0: begin
          start_d    = bus.wr_data[0];
          periodic_d = bus.wr_data[1];
        end
        2'd2:    expr_d  = bus.wr_data;
        2'd3:    count_d = bus.wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      rd_data_q  <= '0;
      rdy_q      <= 1'b1;
      start_q    <= 1'b0;
      periodic_q <= 1'b0;
      flag_q     <= 1'b0;
      expr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      rd_data_q  <= rd_data_d;
      rdy_q      <= rdy_d;
      start_q    <= start_d;
      periodic_q <= periodic_d;
      flag_q     <= flag_d;
      expr_q     <= expr_d;
      count_q    <= count_d;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.rdy_    = rdy_q;
  assign bus.irq     = flag_q;

endmodule

// File: tb/tb_bus_timer_slave.sv
// Self-checking bench for bus_timer_slave: directed tests plus random bus
// traffic checked against a cycle-level behavioural model.
module tb_bus_timer_slave;

  logic clk    = 1'b0;
  logic rst0_n = 1'b0;
  logic rst3_n = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  bus_timer_slave_if b0 ();
  bus_timer_slave_if b3 ();

  bus_timer_slave #(.RDY_WAIT(0)) dut0 (.clk(clk), .reset_(rst0_n), .bus(b0));
  bus_timer_slave #(.RDY_WAIT(3)) dut3 (.clk(clk), .reset_(rst3_n), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model of dut0 (no wait states): registers as plain variables,
  // each bus access acknowledged in the cycle after acceptance.
  logic        m_start, m_per, m_flag, m_ack;
  logic [31:0] m_expr, m_count, m_rdv;
  logic        m_hit, m_acc, m_wr;

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {30'd0, m_per, m_start};
      2'd1:    return {31'd0, m_flag};
      2'd2:    return m_expr;
      default: return m_count;
    endcase
  endfunction

  assign m_hit = m_start && ((m_expr - m_count) == 32'd0);
  assign m_acc = !m_ack && !b0.cs_ && !b0.as_;
  assign m_wr  = m_acc && !b0.rw;

  always @(posedge clk or negedge rst0_n) begin
    if (!rst0_n) begin
      m_start <= 1'b0; m_per <= 1'b0; m_flag <= 1'b0; m_ack <= 1'b0;
      m_expr  <= 32'd0; m_count <= 32'd0; m_rdv <= 32'd0;
    end else begin
      m_ack <= m_acc;
      m_rdv <= (m_acc && b0.rw) ? m_reg(b0.addr) : 32'd0;
      if (m_wr && b0.addr == 2'd0) begin
        m_start <= b0.wr_data[0];
        m_per   <= b0.wr_data[1];
      end else if (m_hit && !m_per) begin
        m_start <= 1'b0;
      end
      if (m_wr && b0.addr == 2'd3) m_count <= b0.wr_data;
      else if (m_start)            m_count <= m_hit ? 32'd0 : m_count + 32'd1;
      if (m_hit)                             m_flag <= 1'b1;
      else if (m_wr && b0.addr == 2'd1)      m_flag <= b0.wr_data[0];
      if (m_wr && b0.addr == 2'd2) m_expr <= b0.wr_data;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("sb_rdy0", 32'(b0.rdy_), 32'(!m_ack));
      chk("sb_rd0",  b0.rd_data,   m_rdv);
      chk("sb_irq0", 32'(b0.irq),  32'(m_flag));
    end
  end

  task automatic drive(input int d, input logic cs, input logic as_n, input logic rw,
                       input logic [1:0] a, input logic [31:0] wd);
    if (d == 0) begin
      b0.cs_ = cs; b0.as_ = as_n; b0.rw = rw; b0.addr = a; b0.wr_data = wd;
    end else begin
      b3.cs_ = cs; b3.as_ = as_n; b3.rw = rw; b3.addr = a; b3.wr_data = wd;
    end
  endtask

  function automatic logic get_rdy(input int d);
    return (d == 0) ? b0.rdy_ : b3.rdy_;
  endfunction

  function automatic logic [31:0] get_rd(input int d);
    return (d == 0) ? b0.rd_data : b3.rd_data;
  endfunction

  function automatic logic get_irq(input int d);
    return (d == 0) ? b0.irq : b3.irq;
  endfunction

  // Starts one cycle after the call (request sampled at the next posedge),
  // holds the request until rdy_ is seen, returns at the negedge inside ACK.
  task automatic access(input int d, input logic rw, input logic [1:0] a,
                        input logic [31:0] wd, output logic [31:0] rd);
    int n;
    int lat;
    lat = (d == 0) ? 1 : 4;
    @(negedge clk);
    drive(d, 1'b0, 1'b0, rw, a, wd);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (get_rdy(d) && n < 50);
    chk("latency", 32'(n), 32'(lat));
    rd = get_rd(d);
    drive(d, 1'b1, 1'b1, 1'b1, 2'd0, 32'd0);
  endtask

  logic [31:0] rd;
  logic        r_rw;
  logic [1:0]  r_a;
  logic [31:0] r_wd;
  int          lows;
  int          pos[$];

  initial begin
    drive(0, 1'b1, 1'b1, 1'b1, 2'd0, 32'd0);
    drive(3, 1'b1, 1'b1, 1'b1, 2'd0, 32'd0);
    repeat (3) @(negedge clk);
    rst0_n = 1'b1;
    rst3_n = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;

    // 1: reset state and basic read
    chk("rst_rdy", 32'(b0.rdy_), 32'd1);
    chk("rst_rd",  b0.rd_data,   32'd0);
    chk("rst_irq", 32'(b0.irq),  32'd0);
    access(0, 1'b1, 2'd3, 32'd0, rd);
    chk("t1_count", rd, 32'd0);
    @(negedge clk);
    chk("t1_rdy_after", 32'(b0.rdy_), 32'd1);
    chk("t1_rd_after",  b0.rd_data,   32'd0);

    // 2: one-shot, EXPR=5
    access(0, 1'b0, 2'd2, 32'd5, rd);
    access(0, 1'b0, 2'd0, 32'd1, rd);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("t2_irq", 32'(b0.irq), (k == 6) ? 32'd1 : 32'd0);
    end
    access(0, 1'b1, 2'd0, 32'd0, rd);
    chk("t2_ctrl", rd, 32'd0);
    access(0, 1'b1, 2'd3, 32'd0, rd);
    chk("t2_count", rd, 32'd0);
    access(0, 1'b0, 2'd1, 32'd0, rd);
    repeat (20) @(negedge clk);
    chk("t2_no_refire", 32'(b0.irq), 32'd0);

    // 3: periodic EXPR=3; expiries 4, 8, 12 edges after the CTRL write
    access(0, 1'b0, 2'd2, 32'd3, rd);
    access(0, 1'b0, 2'd0, 32'd3, rd);
    repeat (6) @(negedge clk);
    access(0, 1'b0, 2'd1, 32'd0, rd);
    chk("t3_race_irq", 32'(b0.irq), 32'd1);
    access(0, 1'b0, 2'd1, 32'd0, rd);
    chk("t3_clear_irq", 32'(b0.irq), 32'd0);
    @(negedge clk);
    chk("t3_pre_irq", 32'(b0.irq), 32'd0);
    @(negedge clk);
    chk("t3_next_exp", 32'(b0.irq), 32'd1);
    access(0, 1'b0, 2'd0, 32'd0, rd);
    access(0, 1'b0, 2'd1, 32'd0, rd);

    // 4: wrap through 0xFFFFFFFF
    access(0, 1'b0, 2'd3, 32'hFFFF_FFFE, rd);
    access(0, 1'b0, 2'd2, 32'd1, rd);
    access(0, 1'b0, 2'd0, 32'd1, rd);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t4_irq", 32'(b0.irq), (k == 4) ? 32'd1 : 32'd0);
    end
    access(0, 1'b1, 2'd0, 32'd0, rd);
    chk("t4_ctrl", rd, 32'd0);
    access(0, 1'b0, 2'd1, 32'd0, rd);

    // 5: wait states on dut3
    access(3, 1'b0, 2'd2, 32'hA5A5_0003, rd);
    access(3, 1'b1, 2'd2, 32'd0, rd);
    chk("t5_expr", rd, 32'hA5A5_0003);
    @(negedge clk);
    drive(3, 1'b0, 1'b0, 1'b1, 2'd2, 32'd0);
    pos.delete();
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (!b3.rdy_) begin
        pos.push_back(n);
        chk("t5_held_rd", b3.rd_data, 32'hA5A5_0003);
      end
    end
    drive(3, 1'b1, 1'b1, 1'b1, 2'd0, 32'd0);
    chk("t5_nacks", 32'(pos.size()), 32'd2);
    if (pos.size() == 2) begin
      chk("t5_first", 32'(pos[0]), 32'd4);
      chk("t5_second", 32'(pos[1]), 32'd9);
    end
    repeat (3) @(negedge clk);

    // 6: async reset mid-access on dut3
    access(3, 1'b0, 2'd0, 32'd2, rd);
    access(3, 1'b0, 2'd1, 32'd1, rd);
    @(negedge clk);
    chk("t6_irq_set", 32'(get_irq(3)), 32'd1);
    drive(3, 1'b0, 1'b0, 1'b1, 2'd2, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1 rst3_n = 1'b0;
    #1;
    chk("t6_irq_rst", 32'(b3.irq), 32'd0);
    chk("t6_rdy_rst", 32'(b3.rdy_), 32'd1);
    drive(3, 1'b1, 1'b1, 1'b1, 2'd0, 32'd0);
    @(negedge clk);
    #1 rst3_n = 1'b1;
    lows = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (!b3.rdy_) lows++;
    end
    chk("t6_no_rdy", 32'(lows), 32'd0);
    for (int a = 0; a < 4; a++) begin
      access(3, 1'b1, 2'(a), 32'd0, rd);
      chk("t6_reg_zero", rd, 32'd0);
    end
    chk("t6_irq_after", 32'(get_irq(3)), 32'd0);

    // Random traffic on dut0 against the model
    for (int i = 0; i < 150; i++) begin
      r_rw = 1'($urandom_range(0, 1));
      r_a  = 2'($urandom_range(0, 3));
      case (r_a)
        2'd0:    r_wd = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 3));
        2'd1:    r_wd = $urandom;
        2'd2:    r_wd = 32'($urandom_range(0, 12));
        default: r_wd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 10))
                                                     : 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      endcase
      access(0, r_rw, r_a, r_wd, rd);
      if (r_rw) chk("rnd_rd", rd, m_rdv);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
